// File: rtl/xyolo_vwrite_serializer.sv
// Vector write serializer: reads N_CH-channel result words from internal memory
// and issues one databus write per enabled channel, advancing both pointers.
module xyolo_vwrite_serializer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned ITER_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    output logic                     done,
    input  logic [ADDR_W-1:0]        ext_addr,
    input  logic [MEM_ADDR_W-1:0]    int_addr,
    input  logic [MEM_ADDR_W-1:0]    int_incr,
    input  logic [ITER_W-1:0]        iter,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic                     bypass,
    output logic                     mem_en,
    output logic [MEM_ADDR_W-1:0]    mem_addr,
    input  logic [N_CH*DATA_W-1:0]   mem_rdata,
    output logic                     databus_valid,
    output logic [ADDR_W-1:0]        databus_addr,
    output logic [DATA_W-1:0]        databus_wdata,
    output logic [DATA_W/8-1:0]      databus_wstrb,
    input  logic                     databus_ready
);

    localparam int unsigned WORD_W   = N_CH * DATA_W;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned CH_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRB_W);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_e;

    state_e                  state_q;
    logic                    done_q;
    logic                    mem_en_q;
    logic                    valid_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [ADDR_W-1:0]       ext_ptr_q;
    logic [MEM_ADDR_W-1:0]   int_ptr_q;
    logic [MEM_ADDR_W-1:0]   incr_q;
    logic [ITER_W-1:0]       iter_q;
    logic [ITER_W-1:0]       cnt_q;
    logic [N_CH-1:0]         mask_q;
    logic [N_CH-1:0]         rem_q;
    logic                    bypass_q;
    logic [WORD_W-1:0]       hold_q;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [CH_IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] m);
        logic [CH_IDX_W-1:0] r;
        r = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (m[i]) r = CH_IDX_W'(i);
        end
        return r;
    endfunction

    // Channel 0 sits in the most significant slice of a memory word.
    function automatic logic [DATA_W-1:0] chan_sel(input logic [WORD_W-1:0] w,
                                                   input logic [CH_IDX_W-1:0] idx);
        logic [WORD_W-1:0] sh;
        sh = w << (DATA_W * 32'(idx));
        return sh[WORD_W-1 -: DATA_W];
    endfunction

    logic [N_CH-1:0]     pick_src_c;
    logic [CH_IDX_W-1:0] sel_idx_c;
    logic [N_CH-1:0]     pick_rem_c;
    logic [WORD_W-1:0]   src_data_c;
    logic [DATA_W-1:0]   next_wdata_c;
    logic [ITER_W-1:0]   cnt_next_c;
    logic                last_word_c;
    logic                word_done_c;

    // Channel pick: from the fresh memory word in LATCH, from the holding register in SEND.
    always_comb begin
        pick_src_c   = (state_q == LATCH) ? mask_q : rem_q;
        src_data_c   = (state_q == LATCH) ? mem_rdata : hold_q;
        sel_idx_c    = lowest_idx(pick_src_c);
        pick_rem_c   = pick_src_c & ~(N_CH'(1) << sel_idx_c);
        next_wdata_c = chan_sel(src_data_c, sel_idx_c);
        cnt_next_c   = cnt_q + ITER_W'(1);
        last_word_c  = (cnt_next_c == iter_q);
        word_done_c  = ((state_q == LATCH) && (bypass_q || (mask_q == '0))) ||
                       ((state_q == SEND) && databus_ready && (rem_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            mem_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            wdata_q   <= '0;
            ext_ptr_q <= '0;
            int_ptr_q <= '0;
            incr_q    <= '0;
            iter_q    <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            rem_q     <= '0;
            bypass_q  <= 1'b0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        done_q <= 1'b0;
                        if (iter != '0) begin
                            ext_ptr_q <= ext_addr;
                            int_ptr_q <= int_addr;
                            incr_q    <= int_incr;
                            iter_q    <= iter;
                            mask_q    <= ch_mask;
                            bypass_q  <= bypass;
                            cnt_q     <= '0;
                            mem_en_q  <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                FETCH: begin
                    mem_en_q <= 1'b0;
                    state_q  <= LATCH;
                end
                LATCH: begin
                    hold_q <= mem_rdata;
                    if (!word_done_c) begin
                        valid_q <= 1'b1;
                        wdata_q <= next_wdata_c;
                        rem_q   <= pick_rem_c;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (databus_ready) begin
                        ext_ptr_q <= ext_ptr_q + ADDR_STEP;
                        if (rem_q != '0) begin
                            wdata_q <= next_wdata_c;
                            rem_q   <= pick_rem_c;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Word completion: finish the job or step to the next memory word.
            if (word_done_c) begin
                cnt_q <= cnt_next_c;
                if (last_word_c) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    int_ptr_q <= int_ptr_q + incr_q;
                    mem_en_q  <= 1'b1;
                    state_q   <= FETCH;
                end
            end
        end
    end

    assign done          = done_q;
    assign mem_en        = mem_en_q;
    assign mem_addr      = int_ptr_q;
    assign databus_valid = valid_q;
    assign databus_addr  = ext_ptr_q;
    assign databus_wdata = wdata_q;
    assign databus_wstrb = {STRB_W{1'b1}};

endmodule

// File: tb/tb_xyolo_vwrite_serializer.sv
// Bench for xyolo_vwrite_serializer: queue-based reference of expected memory reads
// and bus writes, checked every cycle, plus directed scenarios and random jobs.
module tb_xyolo_vwrite_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         done;
    logic [31:0]  ext_addr;
    logic [9:0]   int_addr;
    logic [9:0]   int_incr;
    logic [15:0]  iter;
    logic [3:0]   ch_mask;
    logic         bypass;
    logic         mem_en;
    logic [9:0]   mem_addr;
    logic [127:0] mem_rdata;
    logic         databus_valid;
    logic [31:0]  databus_addr;
    logic [31:0]  databus_wdata;
    logic [3:0]   databus_wstrb;
    logic         databus_ready;

    xyolo_vwrite_serializer dut (
        .clk(clk), .rst(rst), .run(run), .done(done),
        .ext_addr(ext_addr), .int_addr(int_addr), .int_incr(int_incr), .iter(iter),
        .ch_mask(ch_mask), .bypass(bypass),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .databus_valid(databus_valid), .databus_addr(databus_addr),
        .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
        .databus_ready(databus_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;
    int cyc;

    logic [127:0] mem [1024];
    logic [9:0]   exp_rd [$];
    logic [31:0]  exp_wa [$];
    logic [31:0]  exp_wd [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory with one cycle of read latency.
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    // Ready pattern: 0 = tied high, 1 = high one cycle in three, 2 = random.
    initial begin
        int phase = 0;
        databus_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: databus_ready = 1'b1;
                1: begin phase = (phase + 1) % 3; databus_ready = (phase == 0); end
                default: databus_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every read and every write beat must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_en) begin
                if (exp_rd.size() == 0) check("unexpected_mem_en", 128'(mem_en), 128'(0));
                else begin
                    check("mem_addr", 128'(mem_addr), 128'(exp_rd[0]));
                    void'(exp_rd.pop_front());
                end
            end
            if (databus_valid) begin
                if (exp_wa.size() == 0) check("unexpected_valid", 128'(databus_valid), 128'(0));
                else begin
                    check("wr_addr", 128'(databus_addr), 128'(exp_wa[0]));
                    check("wr_data", 128'(databus_wdata), 128'(exp_wd[0]));
                    check("wr_strb", 128'(databus_wstrb), 128'(4'hF));
                    if (databus_ready) begin
                        void'(exp_wa.pop_front());
                        void'(exp_wd.pop_front());
                    end
                end
            end
        end
    end

    // Reference: list the reads and writes a job must produce.
    task automatic build(input logic [31:0] ext, input logic [9:0] ia, input logic [9:0] inc,
                         input logic [15:0] it, input logic [3:0] mask, input logic byp);
        logic [31:0] ea = ext;
        logic [9:0]  ma = ia;
        logic [127:0] w;
        for (int k = 0; k < int'(it); k++) begin
            exp_rd.push_back(ma);
            w = mem[ma];
            if (!byp) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[c]) begin
                        exp_wa.push_back(ea);
                        exp_wd.push_back(w[127-32*c -: 32]);
                        ea = ea + 32'd4;
                    end
                end
            end
            ma = ma + inc;
        end
    endtask

    task automatic start_job(input logic [31:0] ext, input logic [9:0] ia, input logic [9:0] inc,
                             input logic [15:0] it, input logic [3:0] mask, input logic byp);
        @(posedge clk);
        #1;
        ext_addr = ext; int_addr = ia; int_incr = inc; iter = it; ch_mask = mask; bypass = byp;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        ext_addr = $urandom; int_addr = 10'($urandom); int_incr = 10'($urandom);
        iter = 16'($urandom); ch_mask = 4'($urandom); bypass = 1'($urandom);
        check("done_low_after_run", 128'(done), 128'(0));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) check("done_timeout", 128'(done), 128'(1));
        @(negedge clk);
        check("reads_left", 128'(exp_rd.size()), 128'(0));
        check("writes_left", 128'(exp_wa.size()), 128'(0));
    endtask

    function automatic int model_cycles(input logic [15:0] it, input logic [3:0] mask, input logic byp);
        if (it == 0) return 1;
        return int'(it) * (2 + (byp ? 0 : $countones(mask)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        logic [9:0]  ia, inc;
        logic [15:0] it;
        logic [3:0]  mk;
        logic        bp;
        int          rm;

        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = '0;
        rst = 1'b0; run = 1'b0; ext_addr = '0; int_addr = '0; int_incr = '0;
        iter = '0; ch_mask = '0; bypass = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 128'(done), 128'(1));
        check("reset_valid", 128'(databus_valid), 128'(0));
        check("reset_mem_en", 128'(mem_en), 128'(0));
        rst = 1'b1;

        // Full mask, two words, ready tied high.
        mem[0] = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        mem[1] = {32'hB0, 32'hB1, 32'hB2, 32'hB3};
        ready_mode = 0;
        build(32'h1000, 10'd0, 10'd1, 16'd2, 4'b1111, 1'b0);
        check("model_wa7", 128'(exp_wa[7]), 128'(32'h101C));
        check("model_wd0", 128'(exp_wd[0]), 128'(32'hA0));
        check("model_wd4", 128'(exp_wd[4]), 128'(32'hB0));
        start_job(32'h1000, 10'd0, 10'd1, 16'd2, 4'b1111, 1'b0);
        wait_done(cyc);
        check("cycles_full", 128'(cyc), 128'(12));

        // Sparse mask with slow ready.
        ready_mode = 1;
        build(32'h4000, 10'd7, 10'd1, 16'd1, 4'b0101, 1'b0);
        check("model_sparse_n", 128'(exp_wa.size()), 128'(2));
        check("model_sparse_a1", 128'(exp_wa[1]), 128'(32'h4004));
        check("model_sparse_d1", 128'(exp_wd[1]), 128'(mem[7][63:32]));
        start_job(32'h4000, 10'd7, 10'd1, 16'd1, 4'b0101, 1'b0);
        wait_done(cyc);

        // Bypass: reads only.
        ready_mode = 0;
        build(32'h5000, 10'd0, 10'd4, 16'd3, 4'b1111, 1'b1);
        check("model_bypass_rd2", 128'(exp_rd[2]), 128'(10'd8));
        start_job(32'h5000, 10'd0, 10'd4, 16'd3, 4'b1111, 1'b1);
        wait_done(cyc);
        check("cycles_bypass", 128'(cyc), 128'(6));

        // Zero-length job.
        start_job(32'h6000, 10'd3, 10'd1, 16'd0, 4'b1111, 1'b0);
        wait_done(cyc);
        check("cycles_iter0", 128'(cyc), 128'(1));

        // Reset during the second write beat abandons the job.
        build(32'h2000, 10'd0, 10'd1, 16'd2, 4'b1111, 1'b0);
        start_job(32'h2000, 10'd0, 10'd1, 16'd2, 4'b1111, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("beat2_valid", 128'(databus_valid), 128'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_done", 128'(done), 128'(1));
        check("midreset_valid", 128'(databus_valid), 128'(0));
        check("midreset_mem_en", 128'(mem_en), 128'(0));
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        rst = 1'b1;
        build(32'h3000, 10'd9, 10'd1, 16'd1, 4'b0011, 1'b0);
        check("model_restart_a0", 128'(exp_wa[0]), 128'(32'h3000));
        start_job(32'h3000, 10'd9, 10'd1, 16'd1, 4'b0011, 1'b0);
        wait_done(cyc);
        check("cycles_restart", 128'(cyc), 128'(4));

        // Address wrap, with a stray run pulse mid-transfer.
        build(32'hFFFF_FFFC, 10'd1020, 10'd3, 16'd3, 4'b0011, 1'b0);
        check("model_wrap_a1", 128'(exp_wa[1]), 128'(32'h0));
        start_job(32'hFFFF_FFFC, 10'd1020, 10'd3, 16'd3, 4'b0011, 1'b0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                ext_addr = 32'h9999_0000; iter = 16'd5; ch_mask = 4'b1000;
                run = 1'b1;
                @(posedge clk);
                #1;
                run = 1'b0;
            end
        join_none
        wait_done(cyc);
        check("cycles_wrap", 128'(cyc), 128'(12));

        // Random jobs.
        for (int j = 0; j < 40; j++) begin
            e  = $urandom;
            ia = 10'($urandom);
            inc = 10'($urandom);
            it = 16'($urandom_range(0, 5));
            mk = 4'($urandom_range(0, 15));
            bp = ($urandom_range(0, 7) == 0);
            rm = $urandom_range(0, 2);
            ready_mode = rm;
            build(e, ia, inc, it, mk, bp);
            start_job(e, ia, inc, it, mk, bp);
            wait_done(cyc);
            if (rm == 0) check("cycles_rand", 128'(cyc), 128'(model_cycles(it, mk, bp)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xyolo_vwrite_serializer.md
XYOLO_VWRITE_SERIALIZER -- requirements
Module: xyolo_vwrite_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of one channel word and of the databus data.
REQ-002 SHALL have parameter N_CH, default 4 (legal range 1 or more), meaning the number of parallel result channels.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning the external databus address width.
REQ-004 SHALL have parameter MEM_ADDR_W, default 10, meaning the internal result-memory address width.
REQ-005 SHALL have parameter ITER_W, default 16, meaning the width of the vector-word count.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port run, input, 1 bit: start pulse, sampled only in IDLE.
REQ-009 SHALL have port done, output, 1 bit: high when idle and no transfer is pending.
REQ-010 SHALL have port ext_addr, input, ADDR_W bits: external byte address of the first write.
REQ-011 SHALL have port int_addr, input, MEM_ADDR_W bits: first internal memory address.
REQ-012 SHALL have port int_incr, input, MEM_ADDR_W bits: internal address step per vector word.
REQ-013 SHALL have port iter, input, ITER_W bits: number of vector words to transfer.
REQ-014 SHALL have port ch_mask, input, N_CH bits: bit i set means channel i is written.
REQ-015 SHALL have port bypass, input, 1 bit: when 1, memory words are read and counted but no bus writes are issued.
REQ-016 SHALL have ports mem_en (output, 1), mem_addr (output, MEM_ADDR_W) and mem_rdata (input, N_CH*DATA_W) forming the memory read port; read latency is 1 cycle.
REQ-017 SHALL have ports databus_valid (output, 1), databus_addr (output, ADDR_W), databus_wdata (output, DATA_W), databus_wstrb (output, DATA_W/8) and databus_ready (input, 1).

Function
REQ-018 SHALL place channel i at mem_rdata[N_CH*DATA_W-1-DATA_W*i -: DATA_W], so channel 0 is the most significant slice.
REQ-019 SHALL implement four states: IDLE, FETCH, LATCH and SEND.
REQ-020 SHALL, in IDLE on run=1, register ext_addr, int_addr, int_incr, iter, ch_mask and bypass, clear the word counter, drive done=0 and move to FETCH; configuration changes after this have no effect until the next run.
REQ-021 SHALL, in IDLE on run=1 with iter=0, stay in IDLE, drive done=0 for exactly one cycle, and make no memory or bus access.
REQ-022 SHALL, in FETCH, drive mem_en=1 with mem_addr equal to the internal pointer for exactly one cycle, then move to LATCH.
REQ-023 SHALL, in LATCH, capture mem_rdata into an N_CH*DATA_W holding register and select the lowest-index set bit of the latched mask.
REQ-024 SHALL, in LATCH, treat the word as complete when bypass=1 or the mask is 0; otherwise it moves to SEND.
REQ-025 SHALL, in SEND, hold databus_valid=1, databus_addr equal to the external pointer, databus_wdata equal to the selected channel of the holding register and databus_wstrb all ones, all stable until databus_ready=1.
REQ-026 SHALL, on databus_ready=1 in SEND, add DATA_W/8 to the external pointer and select the next higher set mask bit; if no set bit remains, the word is complete.
REQ-027 SHALL, on word completion, increment the word counter; if the count equals the latched iter it moves to IDLE with done=1, otherwise it adds int_incr to the internal pointer and moves to FETCH.
REQ-028 SHALL wrap the external pointer modulo 2^ADDR_W and the internal pointer modulo 2^MEM_ADDR_W without flagging.
REQ-029 SHALL ignore run while not in IDLE.
REQ-030 SHALL drive databus_valid=0 outside SEND and mem_en=0 outside FETCH.
REQ-031 SHALL take 2 cycles plus popcount(mask) handshake cycles per word when ready is tied high, giving iter*(2+popcount) cycles from run to done.

Reset
REQ-032 SHALL, with rst=0 at a clock edge, go to IDLE with done=1, databus_valid=0, mem_en=0 and all pointers, counters and the holding register cleared, in any state including mid-SEND.
REQ-033 SHALL treat a held-off databus handshake interrupted by reset as abandoned and not reissue it.

Verification
REQ-034 N_CH=4, mask=4'b1111, iter=2, ext_addr=0x1000, int_addr=0, int_incr=1, ready=1 -> 8 writes to 0x1000..0x101C in order ch0..ch3 of word 0, then word 1; done after 12 cycles.
REQ-035 mask=4'b0101, iter=1, ready toggling 1 in 3 cycles -> exactly 2 writes (ch0 then ch2) to consecutive addresses; valid, addr and wdata stable while ready=0.
REQ-036 bypass=1, iter=3, int_incr=4 -> mem_addr reads 0, 4, 8; databus_valid never asserted; done after 6 cycles.
REQ-037 iter=0 -> done low one cycle; no mem_en and no valid.
REQ-038 rst=0 asserted during the second SEND beat -> next cycle done=1, valid=0; a new run restarts from the newly registered ext_addr.
REQ-039 ext_addr=0xFFFFFFFC with 2 channels -> second write goes to 0x00000000; run pulsed mid-transfer -> ignored.
